// File: rtl/rx_frame_check.sv
// rtl/rx_frame_check.sv - received-frame parity/framing checker with output FIFO and error statistics
//
// Purpose: checks each deserialised frame for parity and stop-bit errors,
// queues data plus error flags in a small FIFO, and keeps saturating
// error/overrun counters and a sticky overrun flag.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid, in_data                frame strobe and data bits (no backpressure)
//   in_parity, in_stop               received parity and stop bits
//   parity_mode                      0 NONE, 1 EVEN, 2 ODD, 3 MARK, 4 SPACE, 5..7 NONE
//   zero_on_error                    replace errored frame data with zeros
//   clear_stats                      clear counters and sticky overrun
//   out_ready, out_valid             FIFO head handshake
//   out_data, out_parity_err,
//   out_frame_err                    FIFO head contents
//   overrun                          sticky dropped-frame flag
//   parity_err_cnt, frame_err_cnt,
//   overrun_cnt                      saturating event counters
//   fifo_level                       current FIFO occupancy
module rx_frame_check #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_parity,
  input  logic                     in_stop,
  input  logic [2:0]               parity_mode,
  input  logic                     zero_on_error,
  input  logic                     clear_stats,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_parity_err,
  output logic                     out_frame_err,
  output logic                     overrun,
  output logic [CNT_W-1:0]         parity_err_cnt,
  output logic [CNT_W-1:0]         frame_err_cnt,
  output logic [CNT_W-1:0]         overrun_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_perr [DEPTH];
  logic              mem_ferr [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     level;

  logic              exp_parity;
  logic              parity_on;
  logic              perr;
  logic              ferr;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] store_data;

  always_comb begin
    exp_parity = 1'b0;
    parity_on  = 1'b1;
    case (parity_mode)
      3'd1:    exp_parity = ^in_data;
      3'd2:    exp_parity = ~^in_data;
      3'd3:    exp_parity = 1'b1;
      3'd4:    exp_parity = 1'b0;
      default: parity_on  = 1'b0;
    endcase
  end

  assign perr       = in_valid && parity_on && (in_parity != exp_parity);
  assign ferr       = in_valid && !in_stop;
  assign store_data = (zero_on_error && (perr || ferr)) ? '0 : in_data;

  assign full = (level == LW'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign out_valid      = (level != '0);
  assign out_data       = out_valid ? mem_data[rd_ptr] : '0;
  assign out_parity_err = out_valid && mem_perr[rd_ptr];
  assign out_frame_err  = out_valid && mem_ferr[rd_ptr];
  assign fifo_level     = level;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    return (ev && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_perr[i] <= 1'b0;
        mem_ferr[i] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= store_data;
        mem_perr[wr_ptr] <= perr;
        mem_ferr[wr_ptr] <= ferr;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Statistics are independent of the FIFO; clear_stats wins over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
      overrun_cnt    <= '0;
    end else if (clear_stats) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
      overrun_cnt    <= '0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end
      parity_err_cnt <= sat_inc(parity_err_cnt, perr);
      frame_err_cnt  <= sat_inc(frame_err_cnt, ferr);
      overrun_cnt    <= sat_inc(overrun_cnt, drop);
    end
  end

endmodule

// File: doc/rx_frame_check.md
RX_FRAME_CHECK -- requirements
Module: rx_frame_check

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning received data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of each error counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  one-cycle strobe: a deserialised frame is present; no backpressure.
REQ-008 in_data  input  DATA_W  received data bits, bit 0 first on line.
REQ-009 in_parity  input  1  received parity bit; ignored in mode NONE.
REQ-010 in_stop  input  1  received stop bit.
REQ-011 parity_mode  input  3  0 NONE, 1 EVEN, 2 ODD, 3 MARK, 4 SPACE; 5..7 treated as NONE.
REQ-012 zero_on_error  input  1  when 1, an errored frame's data is replaced by all zeros.
REQ-013 clear_stats  input  1  synchronous clear of counters and sticky overrun.
REQ-014 out_ready  input  1  consumer accepts the head entry.
REQ-015 out_valid  output  1  FIFO head entry is valid.
REQ-016 out_data  output  DATA_W  head entry data.
REQ-017 out_parity_err  output  1  head entry parity error flag.
REQ-018 out_frame_err  output  1  head entry framing error flag.
REQ-019 overrun  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-020 parity_err_cnt, frame_err_cnt, overrun_cnt  output  CNT_W each  saturating event counters.
REQ-021 fifo_level  output  $clog2(DEPTH)+1  current number of FIFO entries.

Function
REQ-022 Expected parity SHALL be: EVEN ^in_data; ODD ~^in_data; MARK 1; SPACE 0.
REQ-023 Parity error SHALL be in_valid && mode!=NONE && in_parity!=expected; framing error SHALL be in_valid && in_stop==0.
REQ-024 parity_mode and zero_on_error SHALL be sampled only in the in_valid cycle.
REQ-025 Stored data SHALL be zero if zero_on_error && (parity error || framing error), else in_data; flags SHALL be stored unmodified.
REQ-026 A frame SHALL be pushed when in_valid && (level<DEPTH || pop same cycle).
REQ-027 Pop SHALL occur when out_valid && out_ready.
REQ-028 Latency: a pushed frame SHALL appear on out_* at the next clock edge if the FIFO was empty; otherwise order SHALL be strict FIFO.
REQ-029 out_data and the error flags SHALL hold stable while out_valid && !out_ready.
REQ-030 When in_valid arrives with the FIFO full and no pop that cycle, the frame SHALL be dropped, overrun SHALL set, and overrun_cnt SHALL increment.
REQ-031 parity_err_cnt and frame_err_cnt SHALL increment on each detected error, including dropped frames; one frame may increment both.
REQ-032 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-033 clear_stats SHALL zero all counters and overrun, SHALL take priority over a same-cycle increment, and SHALL NOT affect the FIFO.
REQ-034 fifo_level SHALL be unchanged on simultaneous push and pop, +1 on push only, and -1 on pop only.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-036 While rst_n=0, FIFO SHALL be empty, out_valid=0, out_data=0, out flags=0, overrun=0, all counters=0, fifo_level=0.
REQ-037 Reset asserted mid-operation SHALL discard all stored frames immediately; the first in_valid after release SHALL be handled normally.

Verification
REQ-038 EVEN, in_data=0x5A, in_parity=0, in_stop=1 -> next cycle out_valid=1, data 0x5A, both flags 0.
REQ-039 ODD, in_data=0x01, in_parity=1, zero_on_error=1 -> data 0x00, out_parity_err=1, parity_err_cnt=1.
REQ-040 NONE, in_stop=0, zero_on_error=0, in_data=0xC3 -> data 0xC3, out_frame_err=1, frame_err_cnt=1.
REQ-041 out_ready=0, five frames with DEPTH=4 -> fifo_level=4, overrun=1, overrun_cnt=1; drain yields the first four in order.
REQ-042 FIFO full, in_valid and pop in the same cycle -> no overrun, level stays 4.
REQ-043 CNT_W=2, five parity errors -> count stays 3; clear_stats with a same-cycle error -> count 0.
